// File: rtl/dco_tune_encoder.sv
// dco_tune_encoder: binary DCO tuning word -> registered thermometer enables.
// The integer code slews one LSB per clock toward the target so the
// capacitor bank never switches more than one unit element per edge.
// Once the code has settled, a first-order sigma-delta dithers the
// fractional bits onto the thermometer code.
module dco_tune_encoder #(
  parameter int INT_W  = 4,
  parameter int FRAC_W = 6,
  localparam int TH_W  = (1 << INT_W) - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INT_W+FRAC_W-1:0] tune_word,
  input  logic                    tune_valid,
  output logic                    tune_ready,
  input  logic                    dither_en,
  output logic [TH_W-1:0]         therm_out,
  output logic                    settled
);

  typedef enum logic {IDLE, SLEW} state_t;

  state_t             state_q, state_d;
  logic [INT_W-1:0]   target_int, target_d;
  logic [INT_W-1:0]   cur_int, cur_d;
  logic [FRAC_W-1:0]  frac, frac_d;
  logic [FRAC_W-1:0]  acc, acc_d;
  logic               dith, dith_d;

  logic [INT_W-1:0]   word_int;
  logic [FRAC_W-1:0]  word_frac;
  logic               accept;
  logic               accept_new;
  logic [INT_W-1:0]   cur_step;
  logic [FRAC_W:0]    acc_sum;
  logic [INT_W:0]     eff_sum;
  logic [INT_W-1:0]   eff;
  logic [TH_W-1:0]    therm_d;

  assign word_int   = tune_word[INT_W+FRAC_W-1:FRAC_W];
  assign word_frac  = tune_word[FRAC_W-1:0];
  assign tune_ready = (state_q == IDLE);
  assign accept     = tune_valid & tune_ready;
  // An accept that moves the integer code starts a slew this very edge.
  assign accept_new = accept && (word_int != cur_int);
  assign settled    = (cur_int == target_int);

  // One-LSB step toward the target; only used while slewing.
  assign cur_step = (cur_int < target_int) ? cur_int + 1'b1 : cur_int - 1'b1;

  // Next-state: word capture in IDLE, single-step slew in SLEW.
  always_comb begin
    state_d  = state_q;
    target_d = target_int;
    cur_d    = cur_int;
    frac_d   = frac;
    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = word_int;
          frac_d   = word_frac;
          if (accept_new) state_d = SLEW;
        end
      end
      SLEW: begin
        cur_d = cur_step;
        if (cur_step == target_int) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sigma-delta accumulator: runs only while settled in IDLE, frozen
  // during a slew (including the accepting edge), cleared when disabled.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, frac};
    acc_d   = acc;
    dith_d  = 1'b0;
    if (!dither_en) begin
      acc_d = '0;
    end else if (state_q == IDLE && !accept_new) begin
      acc_d  = acc_sum[FRAC_W-1:0];
      dith_d = acc_sum[FRAC_W];
    end
  end

  // Effective code saturates at the top of the bank rather than wrapping.
  always_comb begin
    eff_sum = {1'b0, cur_int} + {{INT_W{1'b0}}, dith};
    eff     = eff_sum[INT_W] ? {INT_W{1'b1}} : eff_sum[INT_W-1:0];
  end

  // Thermometer decode: line i is enabled when i is below the code.
  for (genvar i = 0; i < TH_W; i++) begin : g_therm
    assign therm_d[i] = (INT_W'(i) < eff);
  end

  // State, code and output registers; reset aborts any slew.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      target_int <= '0;
      cur_int    <= '0;
      frac       <= '0;
      acc        <= '0;
      dith       <= 1'b0;
      therm_out  <= '0;
    end else begin
      state_q    <= state_d;
      target_int <= target_d;
      cur_int    <= cur_d;
      frac       <= frac_d;
      acc        <= acc_d;
      dith       <= dith_d;
      therm_out  <= therm_d;
    end
  end

endmodule

// File: tb/tb_dco_tune_encoder.sv
// Directed bench for dco_tune_encoder: expected values are queued when the
// stimulus is applied and popped when the DUT output is sampled.
module tb_dco_tune_encoder;
  localparam int IW = 4;
  localparam int FW = 6;
  localparam int TW = (1 << IW) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [IW+FW-1:0] tune_word = '0;
  logic           tune_valid = 1'b0;
  logic           tune_ready;
  logic           dither_en = 1'b0;
  logic [TW-1:0]  therm_out;
  logic           settled;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  dco_tune_encoder #(.INT_W(IW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst), .tune_word(tune_word), .tune_valid(tune_valid),
    .tune_ready(tune_ready), .dither_en(dither_en), .therm_out(therm_out),
    .settled(settled)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // Present one word for a single edge; samples land just after that edge.
  task automatic offer(input int i, input int f);
    tune_word  = {IW'(i), FW'(f)};
    tune_valid = 1'b1;
    tick();
    tune_valid = 1'b0;
  endtask

  initial begin
    int th1[5];
    int rd1[5];
    int th2[4];
    int th3[8];
    int ones;
    th1 = '{'h0, 'h0, 'h1, 'h3, 'h7};
    rd1 = '{0, 0, 0, 1, 1};
    th2 = '{'h7, 'h7, 'h3, 'h1};
    th3 = '{'h7, 'h7, 'hF, 'h7, 'hF, 'h7, 'hF, 'h7};

    // Reset state
    tick(); tick();
    rst = 1'b0;
    push(0); chk("rst_therm", 32'(therm_out));
    push(1); chk("rst_ready", 32'(tune_ready));
    push(1); chk("rst_settled", 32'(settled));
    push(0); chk("rst_acc", 32'(dut.acc));

    // Upward slew 0 -> 3, no dither
    offer(3, 0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      push(32'(th1[k])); chk($sformatf("up3_therm_%0d", k), 32'(therm_out));
      push(32'(rd1[k])); chk($sformatf("up3_ready_%0d", k), 32'(tune_ready));
    end
    push(1); chk("up3_settled", 32'(settled));

    // Downward slew 3 -> 1
    offer(1, 0);
    push(0); chk("dn1_settled", 32'(settled));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      push(32'(th2[k])); chk($sformatf("dn1_therm_%0d", k), 32'(therm_out));
    end

    // Settle at 3 with frac=32, then enable dither: 7/F alternation
    offer(3, 32);
    tick(); tick(); tick();
    push('h7); chk("d32_pre", 32'(therm_out));
    dither_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      push(32'(th3[k])); chk($sformatf("d32_therm_%0d", k), 32'(therm_out));
    end

    // frac=16: one cycle in four shows the extra element
    dither_en = 1'b0;
    tick(); tick(); tick();
    offer(3, 16);
    push(1); chk("d16_same_int_ready", 32'(tune_ready));
    dither_en = 1'b1;
    tick(); tick();
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (therm_out == 15'h000F) ones++;
      else if (therm_out != 15'h0007) begin
        n_cmp++; n_fail++;
        $display("FAIL d16_value: observed %0h expected 7 or f", therm_out);
      end
    end
    push(4); chk("d16_ones_in_16", 32'(ones));

    // Top of range with dither: saturates at 0x7FFF
    offer(15, 63);
    push(0); chk("sat_ready_slewing", 32'(tune_ready));
    for (int k = 0; k < 14; k++) tick();
    push(1); chk("sat_settled", 32'(settled));
    for (int k = 0; k < 6; k++) begin
      tick();
      push('h7FFF); chk($sformatf("sat_therm_%0d", k), 32'(therm_out));
    end

    // Slew 15 -> 10; a word offered mid-slew must be ignored
    dither_en = 1'b0;
    offer(10, 0);
    tune_word  = {IW'(2), FW'(0)};
    tune_valid = 1'b1;
    tick();
    push(0); chk("ign_ready", 32'(tune_ready));
    tune_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    push('h03FF); chk("ign_therm_done", 32'(therm_out));
    push(1); chk("ign_settled", 32'(settled));
    push(1); chk("ign_ready_done", 32'(tune_ready));
    tick(); tick(); tick();
    push('h03FF); chk("ign_therm_hold", 32'(therm_out));

    // Reset on the second slew edge of a slew to 8
    rst = 1'b1; tick(); rst = 1'b0;
    offer(8, 0);
    tick();
    push('h0001 >> 1); chk("rs_therm_mid", 32'(therm_out));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(0); chk("rs_therm", 32'(therm_out));
    push(1); chk("rs_ready", 32'(tune_ready));
    push(1); chk("rs_settled", 32'(settled));
    push(0); chk("rs_acc", 32'(dut.acc));
    tick(); tick(); tick();
    push(0); chk("rs_therm_hold", 32'(therm_out));
    push(1); chk("rs_ready_hold", 32'(tune_ready));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
